signature_compactor: RTL

//  Downstream stage of the student circuit. Compresses a run of 8-bit circuit

---
 rtl/signature_compactor.sv | 59 +++++
 1 files changed

// File: rtl/signature_compactor.sv
// signature_compactor: frames NUM_SAMPLES valid 8-bit samples into one 16-bit MISR signature (ports: clk, clear, start, in_valid, cct_output -> signature, sample_count, busy, done)
module signature_compactor #(
  parameter logic [15:0] SEED        = 16'h0000,
  parameter logic [15:0] POLY        = 16'h1021,
  parameter int          NUM_SAMPLES = 256,
  parameter int          CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       cct_output,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] sample_count,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  logic [1:0]       state_q, state_d;
  logic [15:0]      sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      sig_q   <= 16'h0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
  end
  assign last = cnt_q == CNT_W'(NUM_SAMPLES - 1);
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (in_valid) begin
        sig_d   = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ {8'h00, cct_output};
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last ? DONE : RUN;
      end
      IDLE, DONE: if (start) begin
        sig_d   = SEED;
        cnt_d   = '0;
        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    signature    = sig_q;
    sample_count = cnt_q;
    busy         = state_q == RUN;
    done         = state_q == DONE;
  end
endmodule
